// File: rtl/backtrack_if.sv
// Conflict/backtrack handshake between the conflict source and the backtrack unit.
// The unit drives the clear mask and the level-reload strobe back to the decision block.
interface backtrack_if #(
    parameter int NUM_VARS  = 8,
    parameter int WIDTH_LVL = 16
);
    logic                          conflict_pulse;
    logic [WIDTH_LVL-1:0]          cur_lvl_i;
    logic [NUM_VARS-1:0]           learnt_mask_i;
    logic [NUM_VARS*3-1:0]         vars_value_i;
    logic [NUM_VARS*WIDTH_LVL-1:0] vars_lvl_i;
    logic                          busy_o;
    logic [NUM_VARS-1:0]           vars_clear_o;
    logic                          apply_bkt_o;
    logic [WIDTH_LVL-1:0]          bkt_lvl_o;
    logic                          unsat_o;

    modport master (
        output conflict_pulse, cur_lvl_i, learnt_mask_i, vars_value_i, vars_lvl_i,
        input  busy_o, vars_clear_o, apply_bkt_o, bkt_lvl_o, unsat_o
    );

    modport slave (
        input  conflict_pulse, cur_lvl_i, learnt_mask_i, vars_value_i, vars_lvl_i,
        output busy_o, vars_clear_o, apply_bkt_o, bkt_lvl_o, unsat_o
    );
endinterface

// File: rtl/backtrack.sv
// Non-chronological backtrack unit: serially scans the learnt clause for the highest
// level below the conflict level, clears everything assigned above it, then reloads the level counter.
module backtrack #(
    parameter int NUM_VARS  = 8,
    parameter int WIDTH_LVL = 16
) (
    input logic        clk,
    input logic        rst,
    backtrack_if.slave bus
);
    localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

    typedef enum logic [2:0] {IDLE, SCAN, CLEAR, APPLY, UNSAT} state_t;

    state_t                        state;
    logic [IDX_W-1:0]              idx;
    logic [WIDTH_LVL-1:0]          target;
    logic [WIDTH_LVL-1:0]          lat_cur;
    logic [NUM_VARS-1:0]           lat_mask;
    logic [NUM_VARS*3-1:0]         lat_value;
    logic [NUM_VARS*WIDTH_LVL-1:0] lat_lvl;

    logic                 busy;
    logic [NUM_VARS-1:0]  vars_clear;
    logic                 apply_bkt;
    logic [WIDTH_LVL-1:0] bkt_lvl;
    logic                 unsat;

    logic [WIDTH_LVL-1:0] sel_lvl;
    logic                 sel_hit;
    logic [WIDTH_LVL-1:0] target_nxt;
    logic [NUM_VARS-1:0]  clear_nxt;

    // The clear mask uses the target including the last scanned var, so CLEAR can
    // present it on the cycle right after the final SCAN step.
    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        sel_lvl    = lat_lvl[idx*WIDTH_LVL +: WIDTH_LVL];
        sel_hit    = lat_mask[idx] && (|lat_value[idx*3 +: 3]) && (sel_lvl < lat_cur);
        target_nxt = (sel_hit && (sel_lvl > target)) ? sel_lvl : target;
        clear_nxt  = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            clear_nxt[i] = (|lat_value[i*3 +: 3]) && (lat_lvl[i*WIDTH_LVL +: WIDTH_LVL] > target_nxt);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the latched
    // clause copies are reset too so no stale data survives a mid-operation reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            target     <= '0;
            lat_cur    <= '0;
            lat_mask   <= '0;
            lat_value  <= '0;
            lat_lvl    <= '0;
            busy       <= 1'b0;
            vars_clear <= '0;
            apply_bkt  <= 1'b0;
            bkt_lvl    <= '0;
            unsat      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.conflict_pulse) begin
                        lat_cur   <= bus.cur_lvl_i;
                        lat_mask  <= bus.learnt_mask_i;
                        lat_value <= bus.vars_value_i;
                        lat_lvl   <= bus.vars_lvl_i;
                        busy      <= 1'b1;
                        if (bus.cur_lvl_i == '0) begin
                            unsat <= 1'b1;
                            state <= UNSAT;
                        end else begin
                            idx    <= '0;
                            target <= '0;
                            state  <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    target <= target_nxt;
                    if (idx == LAST_IDX) begin
                        vars_clear <= clear_nxt;
                        state      <= CLEAR;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                CLEAR: begin
                    vars_clear <= '0;
                    apply_bkt  <= 1'b1;
                    bkt_lvl    <= target + 1'b1;
                    state      <= APPLY;
                end
                APPLY: begin
                    apply_bkt <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                UNSAT: begin
                    // Terminal until reset; further conflicts fall on the floor.
                    state <= UNSAT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o       = busy;
    assign bus.vars_clear_o = vars_clear;
    assign bus.apply_bkt_o  = apply_bkt;
    assign bus.bkt_lvl_o    = bkt_lvl;
    assign bus.unsat_o      = unsat;
endmodule

// File: tb/tb_backtrack.sv
// Self-checking bench for backtrack: directed corner cases plus randomized conflicts,
// each compared cycle by cycle against a loop-based model of the backtrack rules.
module tb_backtrack;
    localparam int N = 8;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    backtrack_if #(.NUM_VARS(N), .WIDTH_LVL(W)) bif ();

    backtrack #(.NUM_VARS(N), .WIDTH_LVL(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int tests  = 0;
    int failed = 0;

    // Current clause image: per-var value (0 = free) and assignment level.
    int         cur;
    bit [N-1:0] mask;
    int         vl[N];
    int         lv[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        bif.cur_lvl_i     = W'(cur);
        bif.learnt_mask_i = mask;
        for (int i = 0; i < N; i++) begin
            bif.vars_value_i[i*3 +: 3] = 3'(vl[i]);
            bif.vars_lvl_i[i*W +: W]   = W'(lv[i]);
        end
    endtask

    // Reference: backjump target is the deepest assigned learnt var strictly below
    // the conflict level (0 if none); everything assigned deeper than it is undone.
    function automatic void model(output int tgt, output logic [N-1:0] clr);
        tgt = 0;
        for (int i = 0; i < N; i++)
            if (mask[i] && vl[i] != 0 && lv[i] < cur && lv[i] > tgt) tgt = lv[i];
        for (int i = 0; i < N; i++)
            clr[i] = (vl[i] != 0) && (lv[i] > tgt);
    endfunction

    task automatic random_case();
        cur  = $urandom_range(1, 9);
        mask = N'($urandom);
        for (int i = 0; i < N; i++) begin
            vl[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 7);
            lv[i] = $urandom_range(0, 10);
        end
    endtask

    function automatic logic [31:0] outs();
        return {21'd0, bif.busy_o, bif.apply_bkt_o, bif.unsat_o, bif.vars_clear_o};
    endfunction

    function automatic logic [31:0] pack(input bit busy, input bit apply, input bit uns,
                                         input logic [N-1:0] clr);
        return {21'd0, busy, apply, uns, clr};
    endfunction

    // Pulse at cycle T, then check every cycle T+1..T+12. With disturb set, the
    // inputs are scrambled after T and a second pulse is issued at T+3.
    task automatic run_conflict(input string tag, input bit disturb);
        int         tgt;
        logic [N-1:0] clr;
        model(tgt, clr);
        drive();
        bif.conflict_pulse = 1'b1;
        cycle();
        bif.conflict_pulse = 1'b0;
        if (disturb) begin
            bif.cur_lvl_i     = W'($urandom_range(1, 9));
            bif.learnt_mask_i = N'($urandom);
            bif.vars_value_i  = (N*3)'($urandom);
            bif.vars_lvl_i    = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int n = 1; n <= 12; n++) begin
            check($sformatf("%s_t%0d", tag, n), outs(),
                  pack(n <= 10, n == 10, 1'b0, (n == 9) ? clr : '0));
            if (n >= 10) check($sformatf("%s_bkt_t%0d", tag, n), 32'(bif.bkt_lvl_o), 32'(W'(tgt + 1)));
            if (disturb) bif.conflict_pulse = (n == 3);
            cycle();
        end
        bif.conflict_pulse = 1'b0;
    endtask

    initial begin
        bif.conflict_pulse = 1'b0;
        cur = 0; mask = '0;
        for (int i = 0; i < N; i++) begin vl[i] = 0; lv[i] = 0; end
        drive();

        // Reset state
        rst = 1'b0;
        cycle();
        cycle();
        check("reset_outs", outs(), pack(0, 0, 0, '0));
        check("reset_bkt", 32'(bif.bkt_lvl_o), 32'd0);
        rst = 1'b1;
        cycle();

        // Basic case: target 3, reload 4
        cur = 5; mask = 8'b0000_0111;
        vl = '{1, 2, 3, 4, 5, 6, 7, 1};
        lv = '{5, 3, 1, 4, 4, 2, 0, 5};
        run_conflict("basic", 1'b0);

        // Only learnt vars at the conflict level: target 0, reload 1
        cur = 5; mask = 8'b0100_0011;
        vl = '{1, 1, 2, 3, 4, 5, 6, 7};
        lv = '{5, 5, 3, 1, 0, 2, 5, 4};
        run_conflict("nolower", 1'b0);

        // Masked but unassigned var below cur must not set the target
        cur = 6; mask = 8'b0000_0011;
        vl = '{0, 2, 1, 1, 1, 1, 1, 0};
        lv = '{5, 2, 3, 6, 1, 0, 4, 9};
        run_conflict("freevar", 1'b0);

        for (int k = 0; k < 6; k++) begin
            random_case();
            run_conflict($sformatf("rand%0d", k), 1'b0);
        end

        // Second pulse and input changes while busy are ignored
        cur = 5; mask = 8'b0000_0111;
        vl = '{1, 2, 3, 4, 5, 6, 7, 1};
        lv = '{5, 3, 1, 4, 4, 2, 0, 5};
        run_conflict("repulse", 1'b1);
        random_case();
        run_conflict("repulse_rand", 1'b1);

        // Reset mid-scan: no strobes afterwards, then a normal conflict completes
        random_case();
        drive();
        bif.conflict_pulse = 1'b1;
        cycle();
        bif.conflict_pulse = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int n = 0; n < 10; n++) begin
            check($sformatf("midrst_t%0d", n), outs(), pack(0, 0, 0, '0));
            cycle();
        end
        check("midrst_bkt", 32'(bif.bkt_lvl_o), 32'd0);
        random_case();
        run_conflict("after_rst", 1'b0);

        // Conflict at level 0 -> sticky UNSAT, later pulses ignored
        cur = 0; mask = 8'hFF;
        drive();
        bif.conflict_pulse = 1'b1;
        cycle();
        bif.conflict_pulse = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            check($sformatf("unsat_t%0d", n), outs(), pack(1, 0, 1, '0));
            if (n == 4) begin
                cur = 3;
                drive();
            end
            bif.conflict_pulse = (n == 4);
            cycle();
        end
        bif.conflict_pulse = 1'b0;
        rst = 1'b0;
        cycle();
        cycle();
        check("unsat_reset", outs(), pack(0, 0, 0, '0));
        rst = 1'b1;
        cycle();
        random_case();
        run_conflict("final", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
